pipe_skid_reg: RTL



---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_data_reg.sv | 43 ++++
 rtl/pipe_skid_reg.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the skid-buffered pipeline stage
//
// Purpose: state encoding of the stage control FSM plus width/limit constants
//          used by pipe_skid_reg and pipe_data_reg.
// Contents:
//   pipe_state_t  : EMPTY (nothing held), BUSY (main holds one entry),
//                   FULL (main and skid both hold an entry)
//   PIPE_WIDTH    : default payload width
//   STALL_CNT_MAX : saturation value of the optional stall counter

package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int          PIPE_WIDTH    = 32;
  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_data_reg.sv
// rtl/pipe_data_reg.sv - WIDTH-bit load-enabled data register with async clear
//
// Purpose: holds one pipeline payload; loads d on a clock edge when en is high.
// Ports:
//   clk   in  : clock, updates on posedge
//   rst_n in  : asynchronous active-low clear (q -> 0)
//   en    in  : load enable
//   d     in  : WIDTH-bit data to load
//   q     out : WIDTH-bit registered data

module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - handshaked pipeline stage register with 2-entry skid buffer
//
// Purpose: full-throughput, 1-cycle-latency stage between CPU pipeline stages.
//          in_ready is decoded from state only, so there is no combinational
//          path from out_ready to in_ready; the skid register absorbs the one
//          beat that arrives while downstream stalls.
// Optional feature macro: PIPE_STALL_CNT_EN adds the stall_count output.
// Ports:
//   clk         in  : clock, posedge
//   rst_n       in  : asynchronous active-low reset
//   flush       in  : synchronous flush, drops all held entries
//   in_data     in  : upstream payload
//   in_valid    in  : upstream payload valid
//   in_ready    out : stage can accept (state != FULL)
//   out_data    out : downstream payload (main register)
//   out_valid   out : out_data valid (state != EMPTY)
//   out_ready   in  : downstream accepts
//   stall_count out : cycles with out_valid && !out_ready, saturating
//                     (only with PIPE_STALL_CNT_EN)

module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0]      stall_count
`endif
);

  pipe_state_t state_q;
  pipe_state_t state_d;

  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             main_from_skid;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    if (flush) begin
      // Any input fire this cycle is dropped; data registers keep stale values.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_en = 1'b1;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            // Main is stalled; park the new beat behind it.
            skid_en = 1'b1;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_data_reg #(.WIDTH(WIDTH)) u_main_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_data_reg #(.WIDTH(WIDTH)) u_skid_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

  assign out_data = main_q;

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Flush does not clear the counter; only reset does.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule
